// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, route codes, flit types and XY routing.
package noc_pkg;

  localparam int FLIT_W  = 16;

  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 14;
  localparam int DX_MSB   = 13;
  localparam int DX_LSB   = 11;
  localparam int DY_MSB   = 10;
  localparam int DY_LSB   = 8;

  typedef enum logic [2:0] {
    ROUTE_N    = 3'b000,
    ROUTE_S    = 3'b001,
    ROUTE_E    = 3'b010,
    ROUTE_W    = 3'b011,
    ROUTE_L    = 3'b100,
    ROUTE_NONE = 3'b111
  } route_e;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  // Dimension-ordered routing: settle X first, then Y (Y grows northward).
  function automatic route_e xy_route(input logic [2:0] dx, input logic [2:0] dy,
                                      input logic [2:0] myX, input logic [2:0] myY);
    route_e r;
    if (dx > myX)      r = ROUTE_E;
    else if (dx < myX) r = ROUTE_W;
    else if (dy > myY) r = ROUTE_N;
    else if (dy < myY) r = ROUTE_S;
    else               r = ROUTE_L;
    return r;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small circular-buffer FIFO holding flits for one router input port.
// The read port shows the head entry combinationally and reads zero when empty.
module flit_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // Storage array needs no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_router.sv
// Router input port: buffers incoming flits, computes the XY route from each
// head flit and holds that route for the whole wormhole packet.
module input_port_router
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [FLIT_W-1:0] data_o,
  output logic [2:0]        address_route_o,
  output logic              req_o,
  input  logic              grant_i,
  output logic              err_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [2:0] MY_X = 3'(X_ID);
  localparam logic [2:0] MY_Y = 3'(Y_ID);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROUTE  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  route_e            r_route;
  logic              r_err;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [FLIT_W-1:0] w_head;
  flit_type_e        w_headType;
  logic              w_push;
  logic              w_pop;
  logic              w_xfer;
  logic              w_orphan;
  logic              w_isStart;
  logic              w_isLast;

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (data_i),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Ready comes only from the registered occupancy, so a full FIFO refuses a
  // push even in a cycle where it also pops.
  assign ready_o    = (w_count != CW'(DEPTH));
  assign w_push     = valid_i & ~w_full;
  assign w_headType = flit_type_e'(w_head[TYPE_MSB:TYPE_LSB]);
  assign w_isStart  = (w_headType == FT_HEAD) || (w_headType == FT_SINGLE);
  assign w_isLast   = (w_headType == FT_TAIL) || (w_headType == FT_SINGLE);
  assign req_o      = (r_state == S_ACTIVE) && !w_empty;
  assign w_xfer     = req_o & grant_i;
  assign w_orphan   = (r_state == S_IDLE) && !w_empty && !w_isStart;
  assign w_pop      = w_xfer | w_orphan;

  assign data_o          = w_head;
  assign address_route_o = r_route;
  assign err_o           = r_err;

  // Packet framing: wait for a head, spend one cycle routing, then forward until the tail leaves.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty && w_isStart) w_nextState = S_ROUTE;
      S_ROUTE:  w_nextState = S_ACTIVE;
      S_ACTIVE: if (w_xfer && w_isLast) w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // State register plus the held route code and the registered orphan-drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_route <= ROUTE_NONE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_err   <= w_orphan;
      if (r_state == S_ROUTE)
        r_route <= xy_route(w_head[DX_MSB:DX_LSB], w_head[DY_MSB:DY_LSB], MY_X, MY_Y);
      else if (w_xfer && w_isLast)
        r_route <= ROUTE_NONE;
    end
  end

endmodule
